// File: rtl/dmem_responder.sv
// Data-memory pipeline stage: multi-cycle access to a local 16-bit RAM with an upstream
// stall, registered writeback forwards and a sticky error flag.
module dmem_responder #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        readEnable,
    input  logic        writeEnable,
    input  logic [15:0] Address,
    input  logic [15:0] storeData,
    input  logic [15:0] aluOutput,
    input  logic        writeRegp3,
    input  logic [2:0]  regAddressp3,
    output logic [15:0] loadData,
    output logic [15:0] aluOutputp4,
    output logic        writeRegp4,
    output logic [2:0]  regAddressp4,
    output logic        memToReg,
    output logic        stall,
    output logic        memError
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int unsigned DEPTH  = 1 << ADDR_BITS;
    localparam int unsigned LAST_I = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
    localparam logic [1:0]  LAST   = LAST_I[1:0];

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        lat_rd_q, lat_rd_d;
    logic [15:0] lat_addr_q, lat_addr_d;
    logic [15:0] lat_data_q, lat_data_d;
    logic [15:0] load_q, load_d;
    logic [15:0] alu_q, alu_d;
    logic        wreg_q, wreg_d;
    logic [2:0]  raddr_q, raddr_d;
    logic        m2r_q, m2r_d;
    logic        err_q, err_d;

    logic [15:0] mem_q [DEPTH];

    logic        req, both, done, stall_c;
    logic        acc_rd, acc_legal, mem_we;
    logic [15:0] acc_addr, acc_data, rd_word;

    always_comb begin
        req        = readEnable ^ writeEnable;
        both       = readEnable & writeEnable;
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_rd_d   = lat_rd_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        done       = 1'b0;
        stall_c    = 1'b0;
        acc_rd     = lat_rd_q;
        acc_addr   = lat_addr_q;
        acc_data   = lat_data_q;

        // With no wait states the access is served straight from the live inputs.
        if (WAIT_CYCLES == 0) begin
            done     = req;
            acc_rd   = readEnable;
            acc_addr = Address;
            acc_data = storeData;
        end else if (state_q == IDLE) begin
            if (req) begin
                stall_c    = 1'b1;
                state_d    = BUSY;
                cnt_d      = 2'd0;
                lat_rd_d   = readEnable;
                lat_addr_d = Address;
                lat_data_d = storeData;
            end
        end else begin
            if (cnt_q == LAST) begin
                done    = 1'b1;
                state_d = IDLE;
                cnt_d   = 2'd0;
            end else begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        acc_legal = ((acc_addr >> ADDR_BITS) == 16'h0000);
        rd_word   = mem_q[acc_addr[ADDR_BITS-1:0]];
        mem_we    = done & ~acc_rd & acc_legal & rst_n;
    end

    always_comb begin
        load_d  = load_q;
        alu_d   = alu_q;
        wreg_d  = 1'b0;
        raddr_d = raddr_q;
        m2r_d   = m2r_q;
        err_d   = err_q;

        if (!stall_c) begin
            alu_d   = aluOutput;
            wreg_d  = writeRegp3;
            raddr_d = regAddressp3;
            m2r_d   = 1'b0;
        end

        if (done) begin
            if (acc_rd) begin
                load_d = acc_legal ? rd_word : 16'h0000;
                m2r_d  = 1'b1;
            end else begin
                m2r_d  = 1'b0;
            end
            if (!acc_legal) begin
                err_d = 1'b1;
            end
        end

        // While BUSY the request inputs belong to the held access and are not re-decoded.
        if (both && (state_q == IDLE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lat_rd_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            load_q     <= '0;
            alu_q      <= '0;
            wreg_q     <= 1'b0;
            raddr_q    <= '0;
            m2r_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_rd_q   <= lat_rd_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            load_q     <= load_d;
            alu_q      <= alu_d;
            wreg_q     <= wreg_d;
            raddr_q    <= raddr_d;
            m2r_q      <= m2r_d;
            err_q      <= err_d;
        end
    end

    // RAM is deliberately outside the reset domain so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_addr[ADDR_BITS-1:0]] <= acc_data;
        end
    end

    assign loadData     = load_q;
    assign aluOutputp4  = alu_q;
    assign writeRegp4   = wreg_q;
    assign regAddressp4 = raddr_q;
    assign memToReg     = m2r_q;
    assign memError     = err_q;
    assign stall        = stall_c;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four lanes (WAIT_CYCLES 0..3) each driven by a transaction-level
// model; a single process compares every lane's outputs against its model each cycle.
module tb_dmem_responder;

    typedef struct packed {
        logic        st;
        logic [15:0] ld;
        logic [15:0] alu;
        logic        wr;
        logic [2:0]  ra;
        logic        m2r;
        logic        err;
    } obs_t;

    localparam int unsigned LANES     = 4;
    localparam int unsigned CYC_LIMIT = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    obs_t act_a   [LANES];
    obs_t exp_a   [LANES];
    obs_t pin_a   [LANES];
    obs_t pin_m_a [LANES];
    bit   pin_v_a [LANES];
    bit   en_a    [LANES];
    bit   fin_a   [LANES];

    int n_cmp;
    int n_bad;

    for (genvar g = 0; g < LANES; g++) begin : lane
        localparam int unsigned W = 32'(g);

        logic        rst_n, re, we, wr3, st, wr4, m2r, err;
        logic [15:0] addr, sd, alu, ld, alu4;
        logic [2:0]  ra3, ra4;
        obs_t        e, pin, pin_m;
        bit          pin_v, en, fin;
        logic [15:0] mm [4096];

        dmem_responder #(.ADDR_BITS(12), .WAIT_CYCLES(W)) dut (
            .clk(clk), .rst_n(rst_n), .readEnable(re), .writeEnable(we),
            .Address(addr), .storeData(sd), .aluOutput(alu), .writeRegp3(wr3),
            .regAddressp3(ra3), .loadData(ld), .aluOutputp4(alu4), .writeRegp4(wr4),
            .regAddressp4(ra4), .memToReg(m2r), .stall(st), .memError(err)
        );

        assign act_a[g]   = {st, ld, alu4, wr4, ra4, m2r, err};
        assign exp_a[g]   = e;
        assign pin_a[g]   = pin;
        assign pin_m_a[g] = pin_m;
        assign pin_v_a[g] = pin_v;
        assign en_a[g]    = en;
        assign fin_a[g]   = fin;

        function automatic logic [15:0] pool(input logic [3:0] ix);
            return {4'h0, ix, 4'h0, ix};
        endfunction

        // One instruction: held while the model says stall, then retired at the next edge.
        task automatic op(input logic rd, input logic wrt, input logic [15:0] a,
                          input logic [15:0] d, input bit perturb);
            logic        acc, legal;
            int unsigned c;
            re  = rd;
            we  = wrt;
            addr = a;
            sd  = d;
            alu = 16'($urandom);
            wr3 = 1'($urandom);
            ra3 = 3'($urandom);
            acc   = rd ^ wrt;
            legal = (a[15:12] == 4'h0);
            c = 0;
            e.st = acc && (W > 0);
            while (e.st) begin
                @(posedge clk); #1;
                pin_v = 1'b0;
                e.wr = 1'b0;
                c++;
                e.st = (c < W);
                if (perturb) begin
                    alu  = 16'($urandom);
                    wr3  = 1'($urandom);
                    ra3  = 3'($urandom);
                    addr = 16'($urandom);
                    sd   = 16'($urandom);
                end
            end
            @(posedge clk); #1;
            pin_v = 1'b0;
            e.alu = alu;
            e.wr  = wr3;
            e.ra  = ra3;
            e.m2r = 1'b0;
            if (acc && rd) begin
                e.m2r = 1'b1;
                e.ld  = legal ? mm[a[11:0]] : 16'h0000;
            end
            if (acc && wrt && legal) mm[a[11:0]] = d;
            if ((acc && !legal) || (rd && wrt)) e.err = 1'b1;
            e.st = 1'b0;
        endtask

        task automatic rand_op(input bit allow_err);
            int unsigned k;
            logic [15:0] a;
            bit          pb;
            k  = $urandom_range(0, 99);
            a  = pool(4'($urandom));
            pb = 1'($urandom);
            if (allow_err && ($urandom_range(0, 99) < 10)) a[15:12] = 4'($urandom_range(1, 15));
            if (k < 20)                   op(1'b0, 1'b0, a, 16'($urandom), pb);
            else if (k < 55)              op(1'b1, 1'b0, a, 16'($urandom), pb);
            else if (k < 90)              op(1'b0, 1'b1, a, 16'($urandom), pb);
            else if (allow_err)           op(1'b1, 1'b1, a, 16'($urandom), pb);
            else                          op(1'b1, 1'b0, a, 16'($urandom), pb);
        endtask

        task automatic do_reset();
            rst_n = 1'b0;
            re = 1'b0; we = 1'b0; addr = '0; sd = '0; alu = '0; wr3 = 1'b0; ra3 = '0;
            e = '0;
            pin = '0; pin_m = '1; pin_v = 1'b1;
            @(posedge clk); #1;
            pin_v = 1'b0;
            rst_n = 1'b1;
        endtask

        task automatic pin_load(input logic [15:0] v);
            pin = '0; pin.ld = v; pin.m2r = 1'b1;
            pin_m = '0; pin_m.ld = '1; pin_m.m2r = 1'b1;
            pin_v = 1'b1;
        endtask

        initial begin
            fin = 1'b0;
            pin = '0; pin_m = '0; pin_v = 1'b0;
            en = 1'b1;
            do_reset();
            for (int unsigned i = 0; i < 16; i++) op(1'b0, 1'b1, pool(4'(i)), 16'($urandom), 1'b0);

            op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
            op(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
            pin_load(16'hBEEF);
            op(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0);
            op(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
            pin_load(16'h1234);
            op(1'b0, 1'b1, 16'h0030, 16'h5A5A, 1'b0);
            op(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1);
            pin_load(16'h5A5A);

            for (int unsigned i = 0; i < 200; i++) rand_op(1'b0);

            op(1'b1, 1'b0, 16'hF000, 16'h0000, 1'b0);
            pin = '0; pin.m2r = 1'b1; pin.err = 1'b1;
            pin_m = '0; pin_m.ld = '1; pin_m.m2r = 1'b1; pin_m.err = 1'b1;
            pin_v = 1'b1;

            for (int unsigned i = 0; i < 100; i++) rand_op(1'b1);

            // Accept a write to 0x0010, then pull reset before it can retire.
            re = 1'b0; we = 1'b1; addr = 16'h0010; sd = 16'hDEAD;
            alu = 16'($urandom); wr3 = 1'b1; ra3 = 3'($urandom);
            e.st = (W > 0);
            @(posedge clk); #1;
            pin_v = 1'b0;
            if (W == 0) mm[12'h010] = 16'hDEAD;
            do_reset();
            op(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
            pin_load((W == 0) ? 16'hDEAD : 16'hBEEF);

            for (int unsigned i = 0; i < 60; i++) rand_op(1'b0);
            for (int unsigned i = 0; i < 16; i++) op(1'b1, 1'b0, pool(4'(i)), 16'h0000, 1'b0);

            re = 1'b0; we = 1'b0;
            e.st = 1'b0;
            @(negedge clk); #1;
            fin = 1'b1;
        end
    end

    task automatic cmp(input int unsigned ln, input string nm,
                       input logic [63:0] actv, input logic [63:0] expv);
        n_cmp++;
        if (actv !== expv) begin
            n_bad++;
            $display("FAIL %s lane W=%0d t=%0t: got %0h, want %0h", nm, ln, $time, actv, expv);
        end
    endtask

    initial begin
        int unsigned cyc;
        bit          all_done;
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            all_done = 1'b1;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (!fin_a[i]) all_done = 1'b0;
                if (en_a[i] && !fin_a[i]) begin
                    cmp(i, "stall",        64'(act_a[i].st),  64'(exp_a[i].st));
                    cmp(i, "loadData",     64'(act_a[i].ld),  64'(exp_a[i].ld));
                    cmp(i, "aluOutputp4",  64'(act_a[i].alu), 64'(exp_a[i].alu));
                    cmp(i, "writeRegp4",   64'(act_a[i].wr),  64'(exp_a[i].wr));
                    cmp(i, "regAddressp4", 64'(act_a[i].ra),  64'(exp_a[i].ra));
                    cmp(i, "memToReg",     64'(act_a[i].m2r), 64'(exp_a[i].m2r));
                    cmp(i, "memError",     64'(act_a[i].err), 64'(exp_a[i].err));
                    if (pin_v_a[i]) begin
                        cmp(i, "pinned", 64'(act_a[i] & pin_m_a[i]), 64'(pin_a[i] & pin_m_a[i]));
                    end
                end
            end
            if (all_done || (cyc > CYC_LIMIT)) begin
                if (!all_done) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL timeout: lanes unfinished after %0d cycles, want all finished", cyc);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

endmodule
